muller_c_handshake_driver: RTL and testbench
============================================

// Module: muller_c_handshake_driver
// PURPOSE
//  Synchronous four-phase handshake initiator for the Muller C-element under test.
//  Drives the element's two inputs (drv_a, drv_b) through a full up/down cycle, with programmable skew.
//  Synchronizes and observes the element output c_in.
//  Counts completed handshakes; flags timeouts and (optionally) premature output changes.
//  Sits between the io_in pad bank and the c_element instance in muller_c_proj.
// PARAMETERS
//  SYNC_STAGES  2   flops in the c_in synchronizer (>=2)
//  SKEW_W       4   width of skew input (cycles between first and second input edge)
//  TIMEOUT_W    8   width of wait counter; timeout when it reaches 2**TIMEOUT_W-1
//  CNT_W        16  width of completed-handshake counter
// PORTS
//  clock    in   1        system clock
//  reset    in   1        synchronous, active-high reset
//  start    in   1        request one handshake; accepted only in IDLE
//  skew     in   SKEW_W   cycles between first and second driver edge; sampled at accept
//  order    in   1        0: drv_a leads, 1: drv_b leads; sampled at accept
//  c_in     in   1        C-element output (asynchronous; synchronized internally)
//  drv_a    out  1        C-element input A
//  drv_b    out  1        C-element input B
//  busy     out  1        handshake in progress
//  done     out  1        one-cycle pulse on handshake completion
//  timeout  out  1        sticky error; cleared by next accepted start
//  hs_count out  CNT_W    completed handshakes, wraps 2**CNT_W-1 -> 0
//  hold_err out  1        sticky C-element hold violation (see CONFIGURATION)
// BEHAVIOUR
//  - Single clock domain: clock. Reset is synchronous, active-high.
//  - Reset (sampled high at a clock edge; also mid-operation): next cycle state=IDLE.
//    drv_a=drv_b=busy=done=timeout=hold_err=0, hs_count=0, synchronizer flops=0, counters=0.
//  - c_sync = c_in delayed through SYNC_STAGES flops; all decisions use c_sync only.
//  - All outputs are registered.
//  - Accept: start=1 in IDLE -> latch skew/order, clear timeout and hold_err.
//    Cycle N+1: state=UP, busy=1, lead driver=1.
//    If skew=0, lag driver is also 1 in N+1 and state goes directly to WAIT_HI.
//  - start while busy is ignored (no queueing).
//  - UP: skew counter increments; the lag driver rises on the cycle skew counter==skew-1.
//    So lead-to-lag edge spacing is exactly skew cycles. Then state=WAIT_HI and the wait counter clears.
//  - WAIT_HI: wait counter increments each cycle.
//    c_sync=1 -> DOWN: lead driver=0, same skew rules.
//    Counter reaching 2**TIMEOUT_W-1 first -> ERR.
//  - DOWN: lag driver falls after skew cycles (skew=0: both drivers fall together) -> WAIT_LO.
//  - WAIT_LO: c_sync=0 -> DONE; timeout -> ERR.
//  - DONE (1 cycle): done=1, hs_count+=1, busy=0 -> IDLE.
//  - ERR (1 cycle): drv_a=drv_b=0, timeout=1, busy=0 -> IDLE; hs_count unchanged.
//  - c_sync=1 and the timeout terminal count in the same cycle: completion wins.
//  - States: IDLE, UP, WAIT_HI, DOWN, WAIT_LO, DONE, ERR (one-hot or binary, implementer's choice).
// CONFIGURATION
//  MULLER_DRV_HOLD_CHECK_EN defined:
//  - In UP with skew>0 (drivers differ), c_sync must stay 0.
//  - In DOWN with skew>0, c_sync must stay 1.
//  - Deviation sets hold_err=1 next cycle; sticky until next accepted start or reset.
//  - The handshake proceeds normally.
//  MULLER_DRV_HOLD_CHECK_EN undefined: no check logic; hold_err tied 0; port list unchanged.
// TESTING
//  1 reset high 3 cycles mid-handshake -> next cycle all outputs 0, state IDLE, start accepted after.
//  2 ideal C-element model (2-cycle delay), start skew=3 order=0.
//    -> drv_a rises N+1, drv_b rises N+4; done pulses once; hs_count=1; busy low after done.
//  3 skew=0 order=1 -> drv_a and drv_b rise in same cycle and fall in same cycle; done asserted.
//  4 c_in stuck 0, TIMEOUT_W=4 -> ERR after 15 WAIT_HI cycles.
//    drivers 0, timeout=1, hs_count unchanged; next start clears timeout.
//  5 start pulsed while busy -> ignored.
//    Preload via 65535 handshakes -> hs_count wraps 0xFFFF -> 0x0000.
//  6 OR-gate substituted for C-element, skew=3.
//    -> hold_err=1 with MULLER_DRV_HOLD_CHECK_EN; hold_err=0 without; done still pulses.

Source files
------------

// File: rtl/muller_c_handshake_driver.sv
// muller_c_handshake_driver
//   Synchronous four-phase handshake initiator for a Muller C-element.
//   It raises drv_a/drv_b with a programmable skew and waits for the synchronized
//   element output to go high. It then lowers both drivers with the same skew and
//   waits for the output to go low. Completed handshakes are counted, and stalls
//   are flagged as timeouts.
//   Optional feature macro: MULLER_DRV_HOLD_CHECK_EN. When it is defined, the block
//   flags an element output that moves while the drivers disagree (hold_err).
// Ports
//   clock, reset    : system clock, synchronous active-high reset
//   start           : request one handshake (accepted only when idle)
//   skew, order     : lead-to-lag spacing in cycles / 0 = drv_a leads; sampled at accept
//   c_in            : asynchronous C-element output
//   drv_a, drv_b    : C-element inputs
//   busy, done      : handshake in progress / one-cycle completion pulse
//   timeout         : sticky stall error, cleared by the next accepted start
//   hs_count        : completed handshake counter (wraps)
//   hold_err        : sticky hold violation (tied 0 without the check)
module muller_c_handshake_driver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SKEW_W      = 4,
  parameter int unsigned TIMEOUT_W   = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [SKEW_W-1:0] skew,
  input  logic              order,
  input  logic              c_in,
  output logic              drv_a,
  output logic              drv_b,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  hs_count,
  output logic              hold_err
);

  localparam logic [TIMEOUT_W-1:0] WAIT_TERM = '1;

  typedef enum logic [2:0] {
    IDLE, UP, WAIT_HI, DOWN, WAIT_LO, DONE, ERR
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   c_sync;
  logic [SKEW_W-1:0]      skew_q, skew_d, skew_cnt_q, skew_cnt_d;
  logic                   order_q, order_d;
  logic [TIMEOUT_W-1:0]   wait_q, wait_d, wait_inc;
  logic                   drv_a_q, drv_a_d, drv_b_q, drv_b_d;
  logic                   busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
  logic [CNT_W-1:0]       hs_count_q, hs_count_d;
  logic                   lead_d, lag_d;

  assign c_sync   = sync_q[SYNC_STAGES-1];
  assign wait_inc = wait_q + TIMEOUT_W'(1);

  // Next state and next outputs; drivers are handled as lead/lag, then mapped by order
  always_comb begin
    state_d    = state_q;
    skew_d     = skew_q;
    order_d    = order_q;
    skew_cnt_d = skew_cnt_q;
    wait_d     = wait_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timeout_d  = timeout_q;
    hs_count_d = hs_count_q;
    lead_d     = order_q ? drv_b_q : drv_a_q;
    lag_d      = order_q ? drv_a_q : drv_b_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          skew_d     = skew;
          order_d    = order;
          timeout_d  = 1'b0;
          busy_d     = 1'b1;
          lead_d     = 1'b1;
          skew_cnt_d = '0;
          wait_d     = '0;
          if (skew == '0) begin
            lag_d   = 1'b1;
            state_d = WAIT_HI;
          end else begin
            state_d = UP;
          end
        end
      end
      UP: begin
        if (skew_cnt_q == skew_q - SKEW_W'(1)) begin
          lag_d   = 1'b1;
          wait_d  = '0;
          state_d = WAIT_HI;
        end else begin
          skew_cnt_d = skew_cnt_q + SKEW_W'(1);
        end
      end
      WAIT_HI: begin
        // Completion takes priority over the terminal count
        if (c_sync) begin
          lead_d     = 1'b0;
          skew_cnt_d = '0;
          wait_d     = '0;
          if (skew_q == '0) begin
            lag_d   = 1'b0;
            state_d = WAIT_LO;
          end else begin
            state_d = DOWN;
          end
        end else if (wait_inc == WAIT_TERM) begin
          state_d = ERR;
        end else begin
          wait_d = wait_inc;
        end
      end
      DOWN: begin
        if (skew_cnt_q == skew_q - SKEW_W'(1)) begin
          lag_d   = 1'b0;
          wait_d  = '0;
          state_d = WAIT_LO;
        end else begin
          skew_cnt_d = skew_cnt_q + SKEW_W'(1);
        end
      end
      WAIT_LO: begin
        if (!c_sync) begin
          state_d    = DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          hs_count_d = hs_count_q + CNT_W'(1);
        end else if (wait_inc == WAIT_TERM) begin
          state_d = ERR;
        end else begin
          wait_d = wait_inc;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Entering ERR drops both drivers and raises the sticky flag
    if (state_d == ERR && state_q != ERR) begin
      lead_d    = 1'b0;
      lag_d     = 1'b0;
      busy_d    = 1'b0;
      timeout_d = 1'b1;
    end

    drv_a_d = order_d ? lag_d  : lead_d;
    drv_b_d = order_d ? lead_d : lag_d;
  end

  // State, synchronizer and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      skew_q     <= '0;
      skew_cnt_q <= '0;
      order_q    <= 1'b0;
      wait_q     <= '0;
      drv_a_q    <= 1'b0;
      drv_b_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      hs_count_q <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], c_in};
      skew_q     <= skew_d;
      skew_cnt_q <= skew_cnt_d;
      order_q    <= order_d;
      wait_q     <= wait_d;
      drv_a_q    <= drv_a_d;
      drv_b_q    <= drv_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      hs_count_q <= hs_count_d;
    end
  end

  assign drv_a    = drv_a_q;
  assign drv_b    = drv_b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign hs_count = hs_count_q;

`ifdef MULLER_DRV_HOLD_CHECK_EN
  logic hold_err_q, hold_err_d;

  // While the drivers disagree the element must hold its previous output
  always_comb begin
    hold_err_d = hold_err_q;
    if (state_q == IDLE && start) begin
      hold_err_d = 1'b0;
    end else if ((state_q == UP && c_sync) || (state_q == DOWN && !c_sync)) begin
      hold_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) hold_err_q <= 1'b0;
    else       hold_err_q <= hold_err_d;
  end

  assign hold_err = hold_err_q;
`else
  assign hold_err = 1'b0;
`endif

endmodule

// File: tb/tb_muller_c_handshake_driver.sv
// Directed bench for muller_c_handshake_driver. The bench models the element
// as an ideal C-element with a 2-cycle delay, a stuck-at-0 output, or a plain OR gate.
module tb_muller_c_handshake_driver;

  logic       clock = 1'b0;
  logic       reset, start, order, c_in;
  logic [3:0] skew;
  logic       drv_a, drv_b, busy, done, timeout, hold_err;
  logic [3:0] hs_count;

  muller_c_handshake_driver #(
    .SYNC_STAGES(2), .SKEW_W(4), .TIMEOUT_W(4), .CNT_W(4)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .skew(skew), .order(order),
    .c_in(c_in), .drv_a(drv_a), .drv_b(drv_b), .busy(busy), .done(done),
    .timeout(timeout), .hs_count(hs_count), .hold_err(hold_err)
  );

  always #5 clock = ~clock;

  // Element models: 0 ideal C (2-cycle delay), 1 stuck at 0, 2 combinational OR
  int   mode = 0;
  logic c_st = 1'b0, c_d1 = 1'b0;
  always @(posedge clock) begin
    if (drv_a == drv_b) c_st <= drv_a;
    c_d1 <= c_st;
  end
  assign c_in = (mode == 2) ? (drv_a | drv_b) : (mode == 1) ? 1'b0 : c_d1;

`ifdef MULLER_DRV_HOLD_CHECK_EN
  localparam logic HE = 1'b1;
`else
  localparam logic HE = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int exp_hs = 0;
  int ka_r, kb_r, ka_f, kb_f, k_end, n_done;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Issue one start and record the edge timing, relative to the accepting clock edge
  task automatic run_hs(input logic [3:0] sk, input logic ord);
    logic pa, pb;
    @(negedge clock);
    start = 1'b1; skew = sk; order = ord;
    @(negedge clock);
    start = 1'b0;
    ka_r = -1; kb_r = -1; ka_f = -1; kb_f = -1; k_end = -1; n_done = 0;
    pa = 1'b0; pb = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      if (k > 1) @(negedge clock);
      if (drv_a && !pa) ka_r = k;
      if (drv_b && !pb) kb_r = k;
      if (!drv_a && pa) ka_f = k;
      if (!drv_b && pb) kb_f = k;
      pa = drv_a; pb = drv_b;
      if (done) n_done++;
      if (done || (timeout && !busy)) begin
        k_end = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0] sk;
    logic       ord;
    int         mode;
    int         a_r;
    int         b_r;
    int         gap;   // drv_b fall cycle minus drv_a fall cycle
    int         k_end;
    int         n_done;
    logic       to;
    logic       he;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{4'd3, 1'b0, 0, 1, 4,  3, 17, 1, 1'b0, 1'b0};
    tbl[1] = '{4'd0, 1'b1, 0, 1, 1,  0, 11, 1, 1'b0, 1'b0};
    tbl[2] = '{4'd1, 1'b1, 0, 2, 1, -1, 13, 1, 1'b0, 1'b0};
    tbl[3] = '{4'd2, 1'b0, 1, 1, 3,  0, 18, 0, 1'b1, 1'b0};
    tbl[4] = '{4'd5, 1'b0, 0, 1, 6,  5, 21, 1, 1'b0, 1'b0};
    tbl[5] = '{4'd3, 1'b0, 2, 1, 4,  3, 11, 1, 1'b0, HE};
    tbl[6] = '{4'd2, 1'b1, 0, 3, 1, -2, 15, 1, 1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; skew = '0; order = 1'b0;
    idle(3);
    chk("rst_drv_a", int'(drv_a), 0);
    chk("rst_drv_b", int'(drv_b), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_hs_count", int'(hs_count), 0);
    chk("rst_hold_err", int'(hold_err), 0);
    reset = 1'b0;
    idle(2);

    for (int i = 0; i < 7; i++) begin
      idle(8);
      mode = tbl[i].mode;
      idle(4);
      run_hs(tbl[i].sk, tbl[i].ord);
      exp_hs = (exp_hs + tbl[i].n_done) % 16;
      chk($sformatf("v%0d_a_rise", i), ka_r, tbl[i].a_r);
      chk($sformatf("v%0d_b_rise", i), kb_r, tbl[i].b_r);
      chk($sformatf("v%0d_fall_gap", i), kb_f - ka_f, tbl[i].gap);
      chk($sformatf("v%0d_end_cycle", i), k_end, tbl[i].k_end);
      chk($sformatf("v%0d_done_pulses", i), n_done, tbl[i].n_done);
      chk($sformatf("v%0d_timeout", i), int'(timeout), int'(tbl[i].to));
      chk($sformatf("v%0d_hold_err", i), int'(hold_err), int'(tbl[i].he));
      chk($sformatf("v%0d_busy_end", i), int'(busy), 0);
      chk($sformatf("v%0d_drivers_end", i), int'({drv_a, drv_b}), 0);
      chk($sformatf("v%0d_hs_count", i), int'(hs_count), exp_hs);
    end

    // Reset held for three cycles in the middle of a handshake
    mode = 0;
    idle(8);
    @(negedge clock);
    start = 1'b1; skew = 4'd3; order = 1'b0;
    @(negedge clock);
    start = 1'b0;
    idle(4);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("midrst_outputs_c%0d", i),
          int'({drv_a, drv_b, busy, done, timeout, hold_err, hs_count}), 0);
    end
    reset = 1'b0;
    exp_hs = 0;
    idle(8);
    run_hs(4'd3, 1'b0);
    exp_hs = 1;
    chk("post_rst_a_rise", ka_r, 1);
    chk("post_rst_done", n_done, 1);
    chk("post_rst_hs_count", int'(hs_count), exp_hs);

    // Starts that arrive while busy must be ignored
    idle(8);
    @(negedge clock);
    start = 1'b1; skew = 4'd2; order = 1'b0;
    @(negedge clock);
    start = 1'b0;
    n_done = 0; k_end = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clock);
      if (done) begin
        n_done++;
        if (k_end < 0) k_end = k;
      end
      if (k == 2 || k == 8) begin
        start = 1'b1; order = 1'b1; skew = 4'd0;
      end else begin
        start = 1'b0;
      end
    end
    exp_hs = (exp_hs + 1) % 16;
    chk("busy_ign_done_pulses", n_done, 1);
    chk("busy_ign_done_cycle", k_end, 15);
    chk("busy_ign_idle", int'(busy), 0);
    chk("busy_ign_hs_count", int'(hs_count), exp_hs);

    // Sixteen more handshakes walk the 4-bit counter through its wrap
    for (int i = 0; i < 16; i++) begin
      idle(6);
      run_hs(4'd0, 1'b0);
      exp_hs = (exp_hs + 1) % 16;
      chk($sformatf("wrap_hs_count_%0d", i), int'(hs_count), exp_hs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
